// File: rtl/fc_pkg.sv
// Shared definitions for the fully connected stream engine.
// Holds the controller state encoding, the int8 saturation bounds and the
// saturating narrowing helper used when results are quantised.
package fc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LD_FEAT,
        ST_LD_BIAS,
        ST_MAC,
        ST_FINISH,
        ST_SEND
    } fc_state_t;

    localparam int INT8_MAX = 127;
    localparam int INT8_MIN = -128;

    // Callers sign-extend their accumulator-width value to 64 bits first.
    function automatic logic [7:0] sat_int8(input logic signed [63:0] v);
        if (v > 64'(INT8_MAX)) begin
            return 8'(INT8_MAX);
        end
        if (v < 64'(INT8_MIN)) begin
            return 8'(INT8_MIN);
        end
        return 8'(v);
    endfunction

endpackage

// File: rtl/fc_dot_lanes.sv
// Combinational LANES-wide signed int8 dot product.
// Ports:
//   i_feat  packed int8 features, byte k = lane k
//   i_wt    packed int8 weights,  byte k = lane k
//   o_sum   sum of the LANES 16-bit products, sign-extended to ACC_W
// Kept as its own block so a pipeline register can be added later.
module fc_dot_lanes #(
    parameter int DATA_W = 32,
    parameter int LANES  = 4,
    parameter int ACC_W  = 32
) (
    input  logic [DATA_W-1:0]       i_feat,
    input  logic [DATA_W-1:0]       i_wt,
    output logic signed [ACC_W-1:0] o_sum
);

    always_comb begin
        logic signed [15:0] w_prod;
        o_sum  = '0;
        w_prod = '0;
        for (int k = 0; k < LANES; k++) begin
            // 16-bit assignment context keeps the full int8 x int8 product.
            w_prod = $signed(i_feat[8*k +: 8]) * $signed(i_wt[8*k +: 8]);
            o_sum  = o_sum + ACC_W'(w_prod);
        end
    end

endmodule

// File: rtl/fc_stream_engine.sv
// Fully connected layer engine. One AXI-Stream slave carries features,
// biases, then weights (neuron-major); weights are consumed on the fly.
// Results are ReLU'd/shifted/saturated to int8 and streamed out packed,
// and the argmax of the raw accumulators is reported on max_index.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   fc_start, relu_en, out_shift   start pulse and per-run configuration
//   S_AXIS_*                 input packet (TLAST ignored, counts are fixed)
//   M_AXIS_*                 packed int8 results, TLAST on final word
//   max_index, fc_done, busy status
//
// state      | meaning
// IDLE       | waiting for fc_start
// LD_FEAT    | storing feature words
// LD_BIAS    | storing one bias per word
// MAC        | accumulating one weight word per transfer
// FINISH     | argmax update and quantise one neuron (input stalled)
// SEND       | streaming the packed result words
module fc_stream_engine
    import fc_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int LANES   = 4,
    parameter int IN_DIM  = 64,
    parameter int OUT_DIM = 16,
    parameter int ACC_W   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fc_start,
    input  logic                  relu_en,
    input  logic [4:0]            out_shift,
    input  logic [DATA_W-1:0]     S_AXIS_TDATA,
    input  logic                  S_AXIS_TVALID,
    output logic                  S_AXIS_TREADY,
    input  logic                  S_AXIS_TLAST,
    output logic [DATA_W-1:0]     M_AXIS_TDATA,
    output logic                  M_AXIS_TVALID,
    input  logic                  M_AXIS_TREADY,
    output logic                  M_AXIS_TLAST,
    output logic [DATA_W/8-1:0]   M_AXIS_TKEEP,
    output logic [15:0]           max_index,
    output logic                  fc_done,
    output logic                  busy
);

    localparam int FEAT_WORDS = IN_DIM / LANES;
    localparam int OUT_WORDS  = OUT_DIM / LANES;
    localparam int FIDX_W     = (FEAT_WORDS > 1) ? $clog2(FEAT_WORDS) : 1;
    localparam int NIDX_W     = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
    localparam logic [15:0] FEAT_LAST = 16'(FEAT_WORDS - 1);
    localparam logic [15:0] NEUR_LAST = 16'(OUT_DIM - 1);
    localparam logic [15:0] OUTW_LAST = 16'(OUT_WORDS - 1);

    fc_state_t               r_state, w_next;
    logic [15:0]             r_cnt, r_neuron, r_max_idx;
    logic signed [ACC_W-1:0] r_acc, r_best;
    logic                    r_relu, r_done;
    logic [4:0]              r_shift;
    logic [DATA_W-1:0]       r_feat [FEAT_WORDS];
    logic signed [ACC_W-1:0] r_bias [OUT_DIM];
    logic [7:0]              r_out  [OUT_DIM];

    logic                    w_s_ready, w_s_xfer, w_m_xfer;
    logic                    w_feat_last, w_bias_last, w_neur_last, w_out_last;
    logic signed [ACC_W-1:0] w_dot, w_bias_in, w_relu_val, w_shifted;
    logic [7:0]              w_q;
    logic [DATA_W-1:0]       w_m_data;
    logic                    w_unused;

    assign w_unused    = S_AXIS_TLAST;
    assign w_s_ready   = (r_state == ST_LD_FEAT) || (r_state == ST_LD_BIAS) || (r_state == ST_MAC);
    assign w_s_xfer    = w_s_ready && S_AXIS_TVALID;
    assign w_m_xfer    = (r_state == ST_SEND) && M_AXIS_TREADY;
    assign w_feat_last = (r_cnt == FEAT_LAST);
    assign w_bias_last = (r_cnt == NEUR_LAST);
    assign w_out_last  = (r_cnt == OUTW_LAST);
    assign w_neur_last = (r_neuron == NEUR_LAST);
    assign w_bias_in   = ACC_W'($signed(S_AXIS_TDATA[31:0]));

    fc_dot_lanes #(.DATA_W(DATA_W), .LANES(LANES), .ACC_W(ACC_W)) u_dot (
        .i_feat (r_feat[FIDX_W'(r_cnt)]),
        .i_wt   (S_AXIS_TDATA),
        .o_sum  (w_dot)
    );

    // Quantisation of the current neuron's accumulator.
    always_comb begin
        w_relu_val = (r_relu && r_acc[ACC_W-1]) ? '0 : r_acc;
        w_shifted  = w_relu_val >>> r_shift;
        w_q        = sat_int8(64'(w_shifted));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (fc_start) w_next = ST_LD_FEAT;
            ST_LD_FEAT: if (S_AXIS_TVALID && w_feat_last) w_next = ST_LD_BIAS;
            ST_LD_BIAS: if (S_AXIS_TVALID && w_bias_last) w_next = ST_MAC;
            ST_MAC:     if (S_AXIS_TVALID && w_feat_last) w_next = ST_FINISH;
            ST_FINISH:  w_next = w_neur_last ? ST_SEND : ST_MAC;
            ST_SEND:    if (M_AXIS_TREADY && w_out_last) w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    // Buffers carry no reset: every entry is rewritten before it is read.
    always_ff @(posedge clk) begin
        if (w_s_xfer && (r_state == ST_LD_FEAT)) r_feat[FIDX_W'(r_cnt)] <= S_AXIS_TDATA;
        if (w_s_xfer && (r_state == ST_LD_BIAS)) r_bias[NIDX_W'(r_cnt)] <= w_bias_in;
        if (r_state == ST_FINISH)                r_out[NIDX_W'(r_neuron)] <= w_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_neuron  <= '0;
            r_max_idx <= '0;
            r_acc     <= '0;
            r_best    <= '0;
            r_relu    <= 1'b0;
            r_shift   <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_m_xfer && w_out_last;
            case (r_state)
                ST_IDLE: begin
                    if (fc_start) begin
                        r_relu  <= relu_en;
                        r_shift <= out_shift;
                        r_cnt   <= '0;
                    end
                end
                ST_LD_FEAT: begin
                    if (w_s_xfer) r_cnt <= w_feat_last ? 16'd0 : r_cnt + 16'd1;
                end
                ST_LD_BIAS: begin
                    if (w_s_xfer) begin
                        r_cnt <= w_bias_last ? 16'd0 : r_cnt + 16'd1;
                        if (w_bias_last) begin
                            r_neuron <= '0;
                            // With a single neuron bias[0] is the word arriving now.
                            r_acc    <= (r_cnt == 16'd0) ? w_bias_in : r_bias[0];
                        end
                    end
                end
                ST_MAC: begin
                    if (w_s_xfer) begin
                        r_acc <= r_acc + w_dot;
                        r_cnt <= w_feat_last ? 16'd0 : r_cnt + 16'd1;
                    end
                end
                ST_FINISH: begin
                    if ((r_neuron == 16'd0) || (r_acc > r_best)) begin
                        r_best    <= r_acc;
                        r_max_idx <= r_neuron;
                    end
                    r_cnt <= '0;
                    if (!w_neur_last) begin
                        r_neuron <= r_neuron + 16'd1;
                        r_acc    <= r_bias[NIDX_W'(r_neuron + 16'd1)];
                    end
                end
                ST_SEND: begin
                    if (w_m_xfer) r_cnt <= w_out_last ? 16'd0 : r_cnt + 16'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_m_data = '0;
        if (r_state == ST_SEND) begin
            for (int k = 0; k < LANES; k++) begin
                w_m_data[8*k +: 8] = r_out[NIDX_W'(int'(r_cnt) * LANES + k)];
            end
        end
    end

    assign S_AXIS_TREADY = w_s_ready;
    assign M_AXIS_TDATA  = w_m_data;
    assign M_AXIS_TVALID = (r_state == ST_SEND);
    assign M_AXIS_TLAST  = (r_state == ST_SEND) && w_out_last;
    assign M_AXIS_TKEEP  = '1;
    assign max_index     = r_max_idx;
    assign fc_done       = r_done;
    assign busy          = (r_state != ST_IDLE);

endmodule

// File: tb/tb_fc_stream_engine.sv
module tb_fc_stream_engine;

    localparam int DATA_W  = 32;
    localparam int LANES   = 4;
    localparam int IN_DIM  = 64;
    localparam int OUT_DIM = 16;
    localparam int FW      = IN_DIM / LANES;
    localparam int OW      = OUT_DIM / LANES;
    localparam int NW      = FW + OUT_DIM + OUT_DIM * FW;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              fc_start = 1'b0;
    logic              relu_en = 1'b0;
    logic [4:0]        out_shift = '0;
    logic [DATA_W-1:0] S_AXIS_TDATA = '0;
    logic              S_AXIS_TVALID = 1'b0;
    logic              S_AXIS_TREADY;
    logic              S_AXIS_TLAST = 1'b0;
    logic [DATA_W-1:0] M_AXIS_TDATA;
    logic              M_AXIS_TVALID;
    logic              M_AXIS_TREADY = 1'b0;
    logic              M_AXIS_TLAST;
    logic [DATA_W/8-1:0] M_AXIS_TKEEP;
    logic [15:0]       max_index;
    logic              fc_done;
    logic              busy;

    fc_stream_engine #(.DATA_W(DATA_W), .LANES(LANES), .IN_DIM(IN_DIM),
                       .OUT_DIM(OUT_DIM), .ACC_W(32)) dut (
        .clk(clk), .rst(rst), .fc_start(fc_start), .relu_en(relu_en),
        .out_shift(out_shift),
        .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TVALID(S_AXIS_TVALID),
        .S_AXIS_TREADY(S_AXIS_TREADY), .S_AXIS_TLAST(S_AXIS_TLAST),
        .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TVALID(M_AXIS_TVALID),
        .M_AXIS_TREADY(M_AXIS_TREADY), .M_AXIS_TLAST(M_AXIS_TLAST),
        .M_AXIS_TKEEP(M_AXIS_TKEEP), .max_index(max_index),
        .fc_done(fc_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    int   feat [IN_DIM];
    int   bias [OUT_DIM];
    int   wt   [OUT_DIM][IN_DIM];
    bit   cfg_relu;
    int   cfg_shift;
    logic [31:0] exp_w [OW];
    int   exp_max;
    logic [31:0] got_w [OW];
    logic        got_last [OW];

    typedef struct {
        int feat_val; int bias_step; int bias_idx; int bias_val;
        int w_all; int w_idx; int w_val; bit relu; int shift;
        logic [127:0] ew; int emax;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference: plain dot products, strict-greater argmax, ReLU/shift/clamp.
    function automatic void model();
        int acc [OUT_DIM];
        for (int n = 0; n < OUT_DIM; n++) begin
            acc[n] = bias[n];
            for (int i = 0; i < IN_DIM; i++) acc[n] += feat[i] * wt[n][i];
        end
        exp_max = 0;
        for (int n = 1; n < OUT_DIM; n++) if (acc[n] > acc[exp_max]) exp_max = n;
        for (int n = 0; n < OUT_DIM; n++) begin
            int q;
            q = acc[n];
            if (cfg_relu && q < 0) q = 0;
            q = q >>> cfg_shift;
            if (q > 127) q = 127;
            if (q < -128) q = -128;
            exp_w[n / LANES][8 * (n % LANES) +: 8] = 8'(q);
        end
    endfunction

    function automatic logic [31:0] pkt_word(input int idx);
        logic [31:0] w;
        w = '0;
        if (idx < FW) begin
            for (int k = 0; k < LANES; k++) w[8*k +: 8] = 8'(feat[idx * LANES + k]);
        end else if (idx < FW + OUT_DIM) begin
            w = 32'(bias[idx - FW]);
        end else begin
            int r, n, j;
            r = idx - FW - OUT_DIM;
            n = r / FW;
            j = r % FW;
            for (int k = 0; k < LANES; k++) w[8*k +: 8] = 8'(wt[n][j * LANES + k]);
        end
        return w;
    endfunction

    function automatic int rnd8();
        return int'($urandom_range(255)) - 128;
    endfunction

    function automatic void fill_random();
        foreach (feat[i]) feat[i] = rnd8();
        foreach (bias[n]) bias[n] = int'($urandom_range(40000)) - 20000;
        for (int n = 0; n < OUT_DIM; n++)
            for (int i = 0; i < IN_DIM; i++) wt[n][i] = rnd8();
        cfg_relu  = 1'($urandom_range(1));
        cfg_shift = int'($urandom_range(12));
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_tready"}, S_AXIS_TREADY, 0);
        chk({tag, "_tvalid"}, M_AXIS_TVALID, 0);
        chk({tag, "_tlast"},  M_AXIS_TLAST, 0);
        chk({tag, "_tdata"},  M_AXIS_TDATA, 0);
        chk({tag, "_maxidx"}, max_index, 0);
        chk({tag, "_done"},   fc_done, 0);
        chk({tag, "_busy"},   busy, 0);
    endtask

    task automatic do_start();
        @(negedge clk);
        fc_start  = 1'b1;
        relu_en   = cfg_relu;
        out_shift = 5'(cfg_shift);
        @(negedge clk);
        fc_start  = 1'b0;
        relu_en   = ~cfg_relu;
        out_shift = 5'($urandom_range(31));
        chk("busy_after_start", busy, 1);
    endtask

    task automatic send_input(input int n_words, input int gap);
        int idx = 0;
        int budget = 20000;
        while (idx < n_words && budget > 0) begin
            @(negedge clk);
            budget--;
            if (int'($urandom_range(99)) < gap) begin
                S_AXIS_TVALID = 1'b0;
            end else begin
                S_AXIS_TVALID = 1'b1;
                S_AXIS_TDATA  = pkt_word(idx);
            end
            // TREADY depends only on state, so it holds through the coming edge.
            if (S_AXIS_TVALID && S_AXIS_TREADY) idx++;
        end
        if (idx < n_words) chk("in_timeout", idx, n_words);
        @(negedge clk);
        S_AXIS_TVALID = 1'b0;
        if (n_words == NW) begin
            chk("finish_tready_low", S_AXIS_TREADY, 0);
            chk("finish_tvalid_low", M_AXIS_TVALID, 0);
        end
    endtask

    task automatic collect_output(input int gap, input bit poke);
        int k = 0;
        int budget = 5000;
        bit first = 1'b1;
        bit stalled = 1'b0;
        logic [31:0] hold_d = '0;
        logic hold_l = 1'b0;
        while (k < OW && budget > 0) begin
            @(negedge clk);
            budget--;
            if (first) chk("send_latency", M_AXIS_TVALID, 1);
            first = 1'b0;
            if (stalled) begin
                chk("hold_valid", M_AXIS_TVALID, 1);
                chk("hold_data", {M_AXIS_TLAST, M_AXIS_TDATA}, {hold_l, hold_d});
            end
            M_AXIS_TREADY = (int'($urandom_range(99)) >= gap);
            fc_start = poke && M_AXIS_TVALID;
            if (poke && M_AXIS_TVALID) chk("busy_in_send", busy, 1);
            if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                got_w[k]    = M_AXIS_TDATA;
                got_last[k] = M_AXIS_TLAST;
                k++;
                stalled = 1'b0;
            end else begin
                stalled = M_AXIS_TVALID;
                hold_d  = M_AXIS_TDATA;
                hold_l  = M_AXIS_TLAST;
            end
        end
        if (k < OW) chk("out_timeout", k, OW);
        @(negedge clk);
        M_AXIS_TREADY = 1'b0;
        fc_start = 1'b0;
        chk("fc_done_pulse", fc_done, 1);
        chk("busy_after_done", busy, 0);
        chk("no_extra_word", M_AXIS_TVALID, 0);
        @(negedge clk);
        chk("fc_done_clear", fc_done, 0);
        chk("idle_after_done", busy, 0);
    endtask

    task automatic run_packet(input string tag, input int gap_in, input int gap_out, input bit poke);
        do_start();
        send_input(NW, gap_in);
        collect_output(gap_out, poke);
        for (int j = 0; j < OW; j++) begin
            chk({tag, "_data"}, got_w[j], exp_w[j]);
            chk({tag, "_tlast"}, got_last[j], (j == OW - 1));
        end
        chk({tag, "_max_index"}, max_index, exp_max);
    endtask

    vec_t vt [5];

    initial begin
        vt[0] = '{feat_val:2, bias_step:1, bias_idx:-1, bias_val:0, w_all:1, w_idx:-1, w_val:0,
                  relu:0, shift:0, ew:{4{32'h7F7F7F7F}}, emax:15};
        vt[1] = '{feat_val:1, bias_step:1, bias_idx:-1, bias_val:0, w_all:1, w_idx:-1, w_val:0,
                  relu:0, shift:0, ew:{32'h4F4E4D4C, 32'h4B4A4948, 32'h47464544, 32'h43424140}, emax:15};
        vt[2] = '{feat_val:2, bias_step:0, bias_idx:-1, bias_val:0, w_all:0, w_idx:3, w_val:-1,
                  relu:1, shift:0, ew:128'h0, emax:0};
        vt[3] = '{feat_val:2, bias_step:0, bias_idx:-1, bias_val:0, w_all:0, w_idx:3, w_val:-1,
                  relu:0, shift:0, ew:{32'h0, 32'h0, 32'h0, 32'h80000000}, emax:0};
        vt[4] = '{feat_val:3, bias_step:0, bias_idx:5, bias_val:1000, w_all:0, w_idx:-1, w_val:0,
                  relu:0, shift:4, ew:{32'h0, 32'h0, 32'h00003E00, 32'h0}, emax:5};

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        chk("reset_tkeep", M_AXIS_TKEEP, 4'hF);
        rst = 1'b0;

        foreach (vt[v]) begin
            foreach (feat[i]) feat[i] = vt[v].feat_val;
            for (int n = 0; n < OUT_DIM; n++) begin
                bias[n] = n * vt[v].bias_step + ((n == vt[v].bias_idx) ? vt[v].bias_val : 0);
                for (int i = 0; i < IN_DIM; i++) wt[n][i] = (n == vt[v].w_idx) ? vt[v].w_val : vt[v].w_all;
            end
            cfg_relu  = vt[v].relu;
            cfg_shift = vt[v].shift;
            for (int j = 0; j < OW; j++) exp_w[j] = vt[v].ew[32*j +: 32];
            exp_max = vt[v].emax;
            run_packet($sformatf("vec%0d", v), 0, 0, 1'b0);
        end

        for (int r = 0; r < 3; r++) begin
            fill_random();
            model();
            run_packet($sformatf("rand%0d", r), 30, 40, (r == 1));
        end

        // Abort mid-MAC, then a fresh packet must see none of the old data.
        fill_random();
        do_start();
        send_input(FW + OUT_DIM + 21, 20);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b0;
        fill_random();
        model();
        run_packet("after_rst", 25, 25, 1'b0);

        // A start that was ignored during SEND leaves the block idle; a new one works.
        fill_random();
        model();
        run_packet("poke", 0, 50, 1'b1);
        fill_random();
        model();
        run_packet("post_poke", 10, 10, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule
